// File: rtl/phy_tx_lane_ctrl.sv
// phy_tx_lane_ctrl: PCIe transmit-lane sequencer (COM training burst, IDL fill, payload, periodic COM insertion)
module phy_tx_lane_ctrl #(
  parameter int          COM_COUNT    = 4,
  parameter int          SKP_INTERVAL = 16,
  parameter logic [7:0]  IDL_SYM      = 8'h7C,
  parameter logic [7:0]  COM_SYM      = 8'hBC
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic [7:0] data_out,
  output logic       active,
  output logic       sync_done,
  output logic [1:0] state
);
  localparam int CW = $clog2(COM_COUNT) + 1;
  localparam int SW = $clog2(SKP_INTERVAL);
  localparam logic [CW-1:0] COM_LAST = CW'(COM_COUNT - 1);
  localparam logic [SW-1:0] SKP_LAST = SW'(SKP_INTERVAL - 1);
  typedef enum logic [1:0] {OFF = 2'd0, SYNC = 2'd1, IDLE = 2'd2, DATA = 2'd3} st_t;
  st_t st, st_n;
  logic [CW-1:0] com_cnt, com_n;
  logic [SW-1:0] skp_cnt, skp_n;
  logic [7:0] dout_n;
  logic act_n, sync_n, traffic, skp_due;
  assign traffic  = (st == IDLE) || (st == DATA);
  assign skp_due  = traffic && (skp_cnt == SKP_LAST);
  assign fifo_pop = enable && traffic && !fifo_empty && !skp_due;
  assign state    = st;
  always_comb begin
    st_n   = st;
    com_n  = com_cnt;
    skp_n  = skp_cnt;
    dout_n = 8'h00;
    act_n  = 1'b0;
    sync_n = sync_done;
    if (!enable) begin
      st_n   = OFF;
      com_n  = '0;
      skp_n  = '0;
      sync_n = 1'b0;
    end else if (st == OFF) begin
      st_n = SYNC;
    end else if (st == SYNC) begin
      dout_n = COM_SYM;
      st_n   = (com_cnt == COM_LAST) ? IDLE : SYNC;
      com_n  = (com_cnt == COM_LAST) ? '0 : com_cnt + 1'b1;
      sync_n = sync_done || (com_cnt == COM_LAST);
    end else begin
      // a due COM holds the state and lets the FIFO head wait one cycle
      skp_n  = skp_due ? '0 : skp_cnt + 1'b1;
      dout_n = skp_due ? COM_SYM : (fifo_pop ? fifo_data : IDL_SYM);
      act_n  = fifo_pop;
      st_n   = skp_due ? st : (fifo_pop ? DATA : IDLE);
    end
  end
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      st        <= OFF;
      com_cnt   <= '0;
      skp_cnt   <= '0;
      data_out  <= 8'h00;
      active    <= 1'b0;
      sync_done <= 1'b0;
    end else begin
      st        <= st_n;
      com_cnt   <= com_n;
      skp_cnt   <= skp_n;
      data_out  <= dout_n;
      active    <= act_n;
      sync_done <= sync_n;
    end
  end
endmodule
